player_ctrl: RTL and testbench

//  Converts raw left/right push-buttons into the 4-bit player column (plrpos)

---
 rtl/player_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_player_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/player_ctrl.sv
// -----------------------------------------------------------------------------
// player_ctrl
//   Turns the raw left/right push-buttons into the 4-bit player column used by
//   the game core. Each button is synchronised and debounced. A press gives
//   one step. Holding the button auto-repeats. The column is clamped to the
//   playfield, and movement is frozen while lives == 0.
//
// Ports
//   gameclk    in  1  only clock, rising edge
//   clr        in  1  asynchronous active-high reset
//   btn_left   in  1  raw left button, 1 = pressed
//   btn_right  in  1  raw right button, 1 = pressed
//   lives      in  2  lives remaining, 0 = game over
//   plrpos     out 4  player column, 0..MAX_POS
//   moved      out 1  high for the one cycle after plrpos changed
//
// Handshake note: there is no valid/ready traffic here. plrpos is a level.
// moved is a single-cycle strobe that is aligned with the new plrpos value.
// -----------------------------------------------------------------------------
module player_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 20,
  parameter int REPEAT_RATE     = 6,
  parameter int MAX_POS         = 13,
  parameter int START_POS       = 7
) (
  input  logic       gameclk,
  input  logic       clr,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic [1:0] lives,
  output logic [3:0] plrpos,
  output logic       moved
);

  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_REPEAT = 2'd2
  } state_t;

  // Index 0 = left, index 1 = right.
  logic [1:0]    sync1, sync2, deb;
  logic [DW-1:0] dcnt [2];

  state_t        state, state_n;
  logic [RW-1:0] rcnt, rcnt_n;
  logic          dir, dir_n;       // 1 = right, 0 = left
  logic          step;
  logic [3:0]    pos_n;
  logic          moved_n;

  logic          one_held, held_dir, dir_held, alive;

  // ---------------------------------------------------------------------------
  // Two-flop synchroniser for both buttons
  // ---------------------------------------------------------------------------
  always_ff @(posedge gameclk or posedge clr) begin
    if (clr) begin
      sync1 <= 2'b00;
      sync2 <= 2'b00;
    end else begin
      sync1 <= {btn_right, btn_left};
      sync2 <= sync1;
    end
  end

  // ---------------------------------------------------------------------------
  // Debouncers. The counter tracks consecutive samples that disagree with the
  // accepted level. The level flips on the DEBOUNCE_CYCLES-th disagreeing
  // sample.
  // ---------------------------------------------------------------------------
  always_ff @(posedge gameclk or posedge clr) begin
    if (clr) begin
      deb <= 2'b00;
      for (int i = 0; i < 2; i++) dcnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == deb[i]) begin
          dcnt[i] <= '0;
        end else if (dcnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          deb[i]  <= sync2[i];
          dcnt[i] <= '0;
        end else begin
          dcnt[i] <= dcnt[i] + 1'b1;
        end
      end
    end
  end

  assign one_held = deb[0] ^ deb[1];
  assign held_dir = deb[1];
  assign dir_held = one_held && (held_dir == dir);
  assign alive    = (lives != 2'd0);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge gameclk or posedge clr) begin
    if (clr) begin
      state <= S_IDLE;
      rcnt  <= '0;
      dir   <= 1'b0;
    end else begin
      state <= state_n;
      rcnt  <= rcnt_n;
      dir   <= dir_n;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // In WAIT and REPEAT, any change to the held pattern drops back to IDLE. A
  // direction reversal therefore costs one idle cycle before the new step.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_n = state;
    rcnt_n  = rcnt;
    dir_n   = dir;
    step    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (one_held && alive) begin
          step    = 1'b1;
          dir_n   = held_dir;
          rcnt_n  = '0;
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!dir_held || !alive) begin
          state_n = S_IDLE;
          rcnt_n  = '0;
        end else if (rcnt == RW'(REPEAT_DELAY - 1)) begin
          step    = 1'b1;
          rcnt_n  = '0;
          state_n = S_REPEAT;
        end else begin
          rcnt_n  = rcnt + 1'b1;
        end
      end
      S_REPEAT: begin
        if (!dir_held || !alive) begin
          state_n = S_IDLE;
          rcnt_n  = '0;
        end else if (rcnt == RW'(REPEAT_RATE - 1)) begin
          step    = 1'b1;
          rcnt_n  = '0;
        end else begin
          rcnt_n  = rcnt + 1'b1;
        end
      end
      default: begin
        state_n = S_IDLE;
        rcnt_n  = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. The edge checks run before the +/-1, so a step at a
  // playfield edge is absorbed and the column cannot wrap.
  // ---------------------------------------------------------------------------
  always_comb begin
    pos_n   = plrpos;
    moved_n = 1'b0;
    if (step) begin
      if (dir_n && (plrpos != 4'(MAX_POS))) begin
        pos_n   = plrpos + 4'd1;
        moved_n = 1'b1;
      end else if (!dir_n && (plrpos != 4'd0)) begin
        pos_n   = plrpos - 4'd1;
        moved_n = 1'b1;
      end
    end
  end

  always_ff @(posedge gameclk or posedge clr) begin
    if (clr) begin
      plrpos <= 4'(START_POS);
      moved  <= 1'b0;
    end else begin
      plrpos <= pos_n;
      moved  <= moved_n;
    end
  end

endmodule

// File: tb/tb_player_ctrl.sv
// -----------------------------------------------------------------------------
// tb_player_ctrl
//   Directed bench for player_ctrl. The behavioural model describes a hold by
//   its age in cycles. It steps at age 0, at age 20, and every 6 cycles after
//   that. Each negedge compares the DUT against this model. Literal
//   expectations at fixed cycle offsets pin the model to the documented
//   timeline.
// -----------------------------------------------------------------------------
module tb_player_ctrl;

  logic       gameclk = 1'b0;
  logic       clr     = 1'b1;
  logic       btn_left  = 1'b0;
  logic       btn_right = 1'b0;
  logic [1:0] lives   = 2'd3;
  logic [3:0] plrpos;
  logic       moved;

  int n_checks = 0;
  int n_fail   = 0;

  player_ctrl dut (
    .gameclk   (gameclk),
    .clr       (clr),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .lives     (lives),
    .plrpos    (plrpos),
    .moved     (moved)
  );

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  always #5 gameclk = ~gameclk;

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  int m_pos;
  bit m_moved;
  bit ms1 [2];
  bit ms2 [2];
  bit mdeb [2];
  int mrun [2];
  bit m_active;
  int m_dir;     // 1 = right, 0 = left
  int m_age;
  bit m_one;
  int m_cur;
  bit m_step;

  always @(posedge gameclk or posedge clr) begin
    if (clr) begin
      m_pos = 7; m_moved = 0; m_active = 0; m_dir = 0; m_age = 0;
      for (int i = 0; i < 2; i++) begin
        ms1[i] = 0; ms2[i] = 0; mdeb[i] = 0; mrun[i] = 0;
      end
    end else begin
      m_step = 0;
      m_one  = (mdeb[0] != mdeb[1]);
      m_cur  = mdeb[1] ? 1 : 0;
      if (!m_one || lives == 2'd0) begin
        m_active = 0;
      end else if (!m_active) begin
        m_step = 1; m_active = 1; m_dir = m_cur; m_age = 0;
      end else if (m_cur != m_dir) begin
        m_active = 0;
      end else begin
        m_age++;
        if (m_age == 20 || (m_age > 20 && (m_age - 20) % 6 == 0)) m_step = 1;
      end
      m_moved = 0;
      if (m_step) begin
        if (m_dir == 1 && m_pos < 13) begin m_pos++; m_moved = 1; end
        else if (m_dir == 0 && m_pos > 0) begin m_pos--; m_moved = 1; end
      end
      for (int i = 0; i < 2; i++) begin
        if (ms2[i] == mdeb[i]) mrun[i] = 0;
        else begin
          mrun[i]++;
          if (mrun[i] == 4) begin mdeb[i] = ms2[i]; mrun[i] = 0; end
        end
      end
      ms2[0] = ms1[0]; ms2[1] = ms1[1];
      ms1[0] = btn_left; ms1[1] = btn_right;
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard: per-cycle compare against the model
  // ---------------------------------------------------------------------------
  always @(negedge gameclk) begin
    if (!clr) begin
      n_checks++;
      if (plrpos !== 4'(m_pos) || moved !== m_moved) begin
        n_fail++;
        $display("FAIL model_cmp t=%0t: plrpos=%0d moved=%0b, expected plrpos=%0d moved=%0b",
                 $time, plrpos, moved, m_pos, m_moved);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge gameclk);
      #1;
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s t=%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Asserts clr in mid-cycle and checks the asynchronous effect. clr falls
  // 1 ns after the next edge.
  task automatic clr_pulse();
    @(posedge gameclk);
    #3;
    clr = 1'b1;
    #1;
    check("clr_async_pos", int'(plrpos), 7);
    check("clr_async_moved", int'(moved), 0);
    tick();
    clr = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    // Reset
    tick(3);
    check("reset_pos", int'(plrpos), 7);
    check("reset_moved", int'(moved), 0);
    clr = 1'b0;
    tick(3);

    // Tap right for 10 cycles. Expect 7 -> 8 at t0+7 and no further step.
    btn_right = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k == 10) btn_right = 1'b0;
      if (k == 6) check("tap_pos_before", int'(plrpos), 7);
      if (k == 7) begin
        check("tap_pos_step", int'(plrpos), 8);
        check("tap_moved_hi", int'(moved), 1);
      end
      if (k == 8)  check("tap_moved_lo", int'(moved), 0);
      if (k == 40) check("tap_no_repeat", int'(plrpos), 8);
    end

    // Mid-cycle clear brings the column from 8 back to 7.
    clr_pulse();
    tick(3);

    // Hold left from 7 and auto-repeat down to 0, then stay at the edge.
    btn_left = 1'b1;
    for (int k = 1; k <= 75; k++) begin
      tick();
      case (k)
        6:  check("hold_pos6", int'(plrpos), 7);
        7:  check("hold_pos7", int'(plrpos), 6);
        26: check("hold_pos26", int'(plrpos), 6);
        27: check("hold_pos27", int'(plrpos), 5);
        33: check("hold_pos33", int'(plrpos), 4);
        39: check("hold_pos39", int'(plrpos), 3);
        57: begin
          check("hold_pos57", int'(plrpos), 0);
          check("hold_moved57", int'(moved), 1);
        end
        63: begin
          check("hold_edge_pos", int'(plrpos), 0);
          check("hold_edge_moved", int'(moved), 0);
        end
        75: check("hold_end_pos", int'(plrpos), 0);
        default: ;
      endcase
    end
    btn_left = 1'b0;
    tick(12);

    // A 3-cycle glitch on the right button is filtered out.
    btn_right = 1'b1;
    tick(3);
    btn_right = 1'b0;
    tick(20);
    check("glitch_pos", int'(plrpos), 0);

    // Both buttons held together means no button is held.
    btn_left = 1'b1; btn_right = 1'b1;
    tick(50);
    check("both_pos", int'(plrpos), 0);
    btn_left = 1'b0; btn_right = 1'b0;
    tick(12);
    check("both_release_pos", int'(plrpos), 0);

    // Game over while holding right freezes the column. Restoring lives lets
    // stepping resume on the next edge.
    btn_right = 1'b1;
    for (int k = 1; k <= 61; k++) begin
      tick();
      if (k == 7)  check("go_pos7", int'(plrpos), 1);
      if (k == 10) lives = 2'd0;
      if (k == 40) begin
        check("go_frozen", int'(plrpos), 1);
        lives = 2'd3;
      end
      if (k == 41) check("go_resume", int'(plrpos), 2);
      if (k == 60) check("go_pos60", int'(plrpos), 2);
      if (k == 61) check("go_pos61", int'(plrpos), 3);
    end
    btn_right = 1'b0;
    tick(12);
    clr_pulse();
    tick(3);

    // Clear during a hold at 11. The held button then counts as a fresh press.
    btn_right = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k == 39) check("clrhold_pos39", int'(plrpos), 11);
    end
    check("clrhold_pos40", int'(plrpos), 11);
    clr_pulse();
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 6) check("clrhold_wait", int'(plrpos), 7);
      if (k == 7) check("clrhold_step", int'(plrpos), 8);
    end
    btn_right = 1'b0;
    tick(12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
